// File: rtl/lives_controller.sv
// ---------------------------------------------------------------------------
// lives_controller
//   Game-level lives sequencer for the frog game. Owns the lives count, reacts
//   to death / bonus / new-game events, times the death animation and the
//   respawn invulnerability window in frame ticks, and drives the heart
//   display plus respawn / game-over control back to the game FSM.
//
// Ports
//   clk            in   system/pixel clock
//   rst_n          in   asynchronous active-low reset
//   frame_tick     in   1-cycle pulse once per frame
//   new_game       in   1-cycle pulse: start (or restart) a game
//   hit            in   1-cycle pulse: frog killed
//   extra_life     in   1-cycle pulse: bonus life awarded
//   lives          out  current lives count
//   display_lives  out  hearts to draw (lost heart blinks while dying)
//   invuln         out  hit immunity active
//   respawn        out  1-cycle pulse: place frog at start
//   game_over      out  high in GAME_OVER
//   state_o        out  FSM state: 0 GAME_OVER, 1 PLAY, 2 DYING
// ---------------------------------------------------------------------------
module lives_controller #(
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned DEATH_FRAMES  = 60,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       new_game,
    input  logic       hit,
    input  logic       extra_life,
    output logic [1:0] lives,
    output logic [1:0] display_lives,
    output logic       invuln,
    output logic       respawn,
    output logic       game_over,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_GAME_OVER = 2'd0,
        ST_PLAY      = 2'd1,
        ST_DYING     = 2'd2
    } state_t;

    localparam logic [1:0] MAX_L     = 2'(MAX_LIVES);
    localparam logic [1:0] START_L   = 2'(START_LIVES);
    localparam logic [7:0] DEATH_N   = 8'(DEATH_FRAMES);
    localparam logic [7:0] INVULN_N  = 8'(INVULN_FRAMES);
    localparam logic [7:0] BLINK_N   = 8'(BLINK_FRAMES);

    state_t     state, state_n;
    logic [1:0] lives_n, display_n;
    logic       invuln_n, respawn_n, game_over_n;
    logic [7:0] frame_cnt, frame_cnt_n;
    logic [7:0] invuln_cnt, invuln_cnt_n;
    logic [7:0] blink_cnt, blink_cnt_n;
    logic       blink_phase, blink_phase_n;   // 0: show lost heart, 1: hide it

    // NOTE: every next-value gets a default before the case statement, so no
    // path through this block leaves a variable unassigned (no latches).
    always_comb begin
        state_n       = state;
        lives_n       = lives;
        display_n     = display_lives;
        invuln_n      = invuln;
        respawn_n     = 1'b0;
        game_over_n   = game_over;
        frame_cnt_n   = frame_tick ? frame_cnt + 8'd1 : frame_cnt;
        invuln_cnt_n  = invuln_cnt;
        blink_cnt_n   = blink_cnt;
        blink_phase_n = blink_phase;

        unique case (state)
            ST_GAME_OVER: begin
                display_n = 2'd0;
            end

            ST_PLAY: begin
                if (hit && !invuln) begin
                    // Hit wins over a simultaneous extra_life; the coincident
                    // frame tick is swallowed by the counter clear on entry.
                    state_n       = ST_DYING;
                    lives_n       = lives - 2'd1;
                    display_n     = lives;          // new lives + 1: heart shown
                    frame_cnt_n   = 8'd0;
                    blink_cnt_n   = 8'd0;
                    blink_phase_n = 1'b0;
                end else begin
                    if (frame_tick && invuln) begin
                        if (invuln_cnt <= 8'd1) begin
                            invuln_cnt_n = 8'd0;
                            invuln_n     = 1'b0;
                        end else begin
                            invuln_cnt_n = invuln_cnt - 8'd1;
                        end
                    end
                    if (extra_life && (lives < MAX_L))
                        lives_n = lives + 2'd1;
                    display_n = lives_n;
                end
            end

            ST_DYING: begin
                if (frame_tick) begin
                    if (frame_cnt == DEATH_N - 8'd1) begin
                        frame_cnt_n = 8'd0;
                        if (lives == 2'd0) begin
                            state_n     = ST_GAME_OVER;
                            game_over_n = 1'b1;
                            display_n   = 2'd0;
                        end else begin
                            state_n      = ST_PLAY;
                            respawn_n    = 1'b1;
                            invuln_n     = 1'b1;
                            invuln_cnt_n = INVULN_N;
                            display_n    = lives;
                        end
                    end else begin
                        if (blink_cnt == BLINK_N - 8'd1) begin
                            blink_cnt_n   = 8'd0;
                            blink_phase_n = ~blink_phase;
                        end else begin
                            blink_cnt_n = blink_cnt + 8'd1;
                        end
                        display_n = blink_phase_n ? lives : lives + 2'd1;
                    end
                end
            end

            default: begin
                state_n     = ST_GAME_OVER;
                game_over_n = 1'b1;
                display_n   = 2'd0;
            end
        endcase

        // new_game overrides whatever the current state decided.
        if (new_game) begin
            state_n      = ST_PLAY;
            lives_n      = START_L;
            display_n    = START_L;
            invuln_n     = 1'b1;
            invuln_cnt_n = INVULN_N;
            respawn_n    = 1'b1;
            game_over_n  = 1'b0;
            frame_cnt_n  = 8'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_GAME_OVER;
            lives         <= 2'd0;
            display_lives <= 2'd0;
            invuln        <= 1'b0;
            respawn       <= 1'b0;
            game_over     <= 1'b1;
            frame_cnt     <= 8'd0;
            invuln_cnt    <= 8'd0;
            blink_cnt     <= 8'd0;
            blink_phase   <= 1'b0;
        end else begin
            state         <= state_n;
            lives         <= lives_n;
            display_lives <= display_n;
            invuln        <= invuln_n;
            respawn       <= respawn_n;
            game_over     <= game_over_n;
            frame_cnt     <= frame_cnt_n;
            invuln_cnt    <= invuln_cnt_n;
            blink_cnt     <= blink_cnt_n;
            blink_phase   <= blink_phase_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_lives_controller.sv
// ---------------------------------------------------------------------------
// tb_lives_controller
//   Directed self-checking bench for lives_controller with default parameters
//   (3 lives, 60 death frames, 120 invuln frames, 8-frame blink). Inputs are
//   driven on the falling edge; outputs are checked on the following falling
//   edge, half a cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_lives_controller;

    logic       clk;
    logic       rst_n;
    logic       frame_tick, new_game, hit, extra_life;
    logic [1:0] lives, display_lives, state_o;
    logic       invuln, respawn, game_over;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] S_GO = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2;

    lives_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .new_game      (new_game),
        .hit           (hit),
        .extra_life    (extra_life),
        .lives         (lives),
        .display_lives (display_lives),
        .invuln        (invuln),
        .respawn       (respawn),
        .game_over     (game_over),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- stimulus helpers (no checking) ----
    task automatic cyc();
        @(negedge clk);
    endtask

    // Drive the given pulses for one cycle; on return outputs show the result.
    task automatic drive(input logic f, input logic n, input logic h, input logic e);
        frame_tick = f; new_game = n; hit = h; extra_life = e;
        @(negedge clk);
        frame_tick = 0; new_game = 0; hit = 0; extra_life = 0;
    endtask

    task automatic tick_only();
        drive(1, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick_only();
            cyc();
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 0; frame_tick = 0; new_game = 0; hit = 0; extra_life = 0;
        repeat (3) cyc();
        rst_n = 1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            frames(1);
            n_cmp++; if (respawn !== 1'b0) begin n_bad++; $display("FAIL reset_respawn frame %0d: got %b want 0", i, respawn); end
        end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL reset_game_over: got %b want 1", game_over); end
        n_cmp++; if (lives !== 2'd0) begin n_bad++; $display("FAIL reset_lives: got %0d want 0", lives); end
        n_cmp++; if (display_lives !== 2'd0) begin n_bad++; $display("FAIL reset_display: got %0d want 0", display_lives); end
        n_cmp++; if (invuln !== 1'b0) begin n_bad++; $display("FAIL reset_invuln: got %b want 0", invuln); end
        n_cmp++; if (state_o !== S_GO) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        // hit / extra_life ignored in GAME_OVER
        drive(0, 0, 1, 0); drive(0, 0, 0, 1);
        n_cmp++; if (lives !== 2'd0 || state_o !== S_GO) begin n_bad++; $display("FAIL go_ignore: lives %0d state %0d want 0/0", lives, state_o); end
    endtask

    task automatic test_new_game();
        drive(0, 1, 0, 0);
        n_cmp++; if (state_o !== S_PLAY) begin n_bad++; $display("FAIL ng_state: got %0d want 1", state_o); end
        n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL ng_lives: got %0d want 3", lives); end
        n_cmp++; if (display_lives !== 2'd3) begin n_bad++; $display("FAIL ng_display: got %0d want 3", display_lives); end
        n_cmp++; if (invuln !== 1'b1) begin n_bad++; $display("FAIL ng_invuln: got %b want 1", invuln); end
        n_cmp++; if (respawn !== 1'b1) begin n_bad++; $display("FAIL ng_respawn: got %b want 1", respawn); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL ng_game_over: got %b want 0", game_over); end
        cyc();
        n_cmp++; if (respawn !== 1'b0) begin n_bad++; $display("FAIL ng_respawn_width: got %b want 0", respawn); end
        frames(119);
        n_cmp++; if (invuln !== 1'b1) begin n_bad++; $display("FAIL invuln_119: got %b want 1", invuln); end
        tick_only();
        n_cmp++; if (invuln !== 1'b0) begin n_bad++; $display("FAIL invuln_120: got %b want 0", invuln); end
    endtask

    task automatic test_hit_and_blink();
        logic [1:0] exp_disp;
        drive(0, 1, 0, 0);
        frames(50);
        drive(0, 0, 1, 0);
        n_cmp++; if (lives !== 2'd3 || state_o !== S_PLAY) begin n_bad++; $display("FAIL hit_protected: lives %0d state %0d want 3/1", lives, state_o); end
        frames(69);
        n_cmp++; if (invuln !== 1'b1) begin n_bad++; $display("FAIL invuln_still: got %b want 1", invuln); end
        frames(1);
        drive(0, 0, 1, 0);
        n_cmp++; if (state_o !== S_DYING) begin n_bad++; $display("FAIL hit_state: got %0d want 2", state_o); end
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL hit_lives: got %0d want 2", lives); end
        n_cmp++; if (display_lives !== 2'd3) begin n_bad++; $display("FAIL blink_entry: got %0d want 3", display_lives); end
        // ticks 1..59: display 3 during ticks 0-7, 2 during 8-15, 3 during 16-23 ...
        for (int t = 1; t < 60; t++) begin
            frames(1);
            exp_disp = ((t / 8) % 2 == 0) ? 2'd3 : 2'd2;
            n_cmp++; if (display_lives !== exp_disp || state_o !== S_DYING) begin n_bad++; $display("FAIL blink tick %0d: disp %0d state %0d want %0d/2", t, display_lives, state_o, exp_disp); end
        end
        // dying ignores hit / extra_life
        drive(0, 0, 1, 1);
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL dying_ignore: got %0d want 2", lives); end
        tick_only();
        n_cmp++; if (state_o !== S_PLAY || respawn !== 1'b1) begin n_bad++; $display("FAIL respawn60: state %0d respawn %b want 1/1", state_o, respawn); end
        n_cmp++; if (invuln !== 1'b1 || display_lives !== 2'd2) begin n_bad++; $display("FAIL respawn_inv_disp: invuln %b disp %0d want 1/2", invuln, display_lives); end
        cyc();
        n_cmp++; if (respawn !== 1'b0) begin n_bad++; $display("FAIL respawn_pulse: got %b want 0", respawn); end
    endtask

    task automatic test_game_over();
        drive(0, 1, 0, 0);
        for (int k = 2; k >= 1; k--) begin
            frames(120);
            drive(0, 0, 1, 0);
            n_cmp++; if (lives !== 2'(k) || state_o !== S_DYING) begin n_bad++; $display("FAIL go_hit%0d: lives %0d state %0d want %0d/2", k, lives, state_o, k); end
            frames(59); tick_only();
            n_cmp++; if (state_o !== S_PLAY || respawn !== 1'b1) begin n_bad++; $display("FAIL go_respawn%0d: state %0d respawn %b want 1/1", k, state_o, respawn); end
        end
        frames(120);
        drive(0, 0, 1, 0);
        n_cmp++; if (lives !== 2'd0 || display_lives !== 2'd1) begin n_bad++; $display("FAIL last_hit: lives %0d disp %0d want 0/1", lives, display_lives); end
        frames(59); tick_only();
        n_cmp++; if (state_o !== S_GO || game_over !== 1'b1) begin n_bad++; $display("FAIL to_go: state %0d game_over %b want 0/1", state_o, game_over); end
        n_cmp++; if (display_lives !== 2'd0 || lives !== 2'd0) begin n_bad++; $display("FAIL go_disp: disp %0d lives %0d want 0/0", display_lives, lives); end
        n_cmp++; if (respawn !== 1'b0) begin n_bad++; $display("FAIL go_respawn: got %b want 0", respawn); end
    endtask

    task automatic test_extra_life();
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL extra_sat: got %0d want 3", lives); end
        frames(119);
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        frames(59); tick_only();
        drive(0, 0, 0, 1);
        n_cmp++; if (lives !== 2'd3 || display_lives !== 2'd3) begin n_bad++; $display("FAIL extra_inc: lives %0d disp %0d want 3/3", lives, display_lives); end
        frames(120);
        drive(0, 0, 1, 0);
        frames(59); tick_only();
        n_cmp++; if (lives !== 2'd2 || state_o !== S_PLAY) begin n_bad++; $display("FAIL pre_combo: lives %0d state %0d want 2/1", lives, state_o); end
        frames(120);
        // hit + extra_life + frame_tick together: hit wins, tick not counted
        drive(1, 0, 1, 1);
        n_cmp++; if (lives !== 2'd1 || state_o !== S_DYING) begin n_bad++; $display("FAIL combo: lives %0d state %0d want 1/2", lives, state_o); end
        frames(59);
        n_cmp++; if (state_o !== S_DYING) begin n_bad++; $display("FAIL coincident_tick: state %0d want 2", state_o); end
        tick_only();
        n_cmp++; if (state_o !== S_PLAY) begin n_bad++; $display("FAIL combo_respawn: state %0d want 1", state_o); end
        cyc();
    endtask

    task automatic test_back_to_back();
        frames(120);
        drive(0, 0, 1, 0);
        frames(10);
        n_cmp++; if (state_o !== S_DYING || lives !== 2'd0) begin n_bad++; $display("FAIL pre_restart: state %0d lives %0d want 2/0", state_o, lives); end
        drive(0, 1, 0, 0);
        n_cmp++; if (state_o !== S_PLAY || lives !== 2'd3) begin n_bad++; $display("FAIL restart: state %0d lives %0d want 1/3", state_o, lives); end
        n_cmp++; if (invuln !== 1'b1 || respawn !== 1'b1 || display_lives !== 2'd3) begin n_bad++; $display("FAIL restart_flags: invuln %b respawn %b disp %0d want 1/1/3", invuln, respawn, display_lives); end
        frames(5);
        // asynchronous reset mid-PLAY, observed before any rising edge
        #2 rst_n = 0;
        #1;
        n_cmp++; if (state_o !== S_GO || lives !== 2'd0 || game_over !== 1'b1) begin n_bad++; $display("FAIL async_rst: state %0d lives %0d go %b want 0/0/1", state_o, lives, game_over); end
        n_cmp++; if (invuln !== 1'b0 || display_lives !== 2'd0 || respawn !== 1'b0) begin n_bad++; $display("FAIL async_rst_out: invuln %b disp %0d respawn %b want 0/0/0", invuln, display_lives, respawn); end
        cyc();
        rst_n = 1;
        cyc();
        drive(0, 1, 0, 0);
        n_cmp++; if (state_o !== S_PLAY || lives !== 2'd3) begin n_bad++; $display("FAIL post_rst_ng: state %0d lives %0d want 1/3", state_o, lives); end
    endtask

    initial begin
        test_reset();
        test_new_game();
        test_hit_and_blink();
        test_game_over();
        test_extra_life();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
